// File: rtl/dac_spi_rx_pkg.sv
// rtl/dac_spi_rx_pkg.sv - shared command codes, broadcast address and FSM encoding
package dac_spi_rx_pkg;

    localparam logic [3:0] CMD_WR_IN  = 4'h0;
    localparam logic [3:0] CMD_UPD    = 4'h1;
    localparam logic [3:0] CMD_WR_UPD = 4'h3;
    localparam logic [3:0] CMD_RST    = 4'h7;

    localparam logic [3:0] ADDR_BCAST = 4'hF;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2,
        EVAL      = 2'd3
    } state_t;

endpackage

// File: rtl/dac_spi_rx_spi_in_sync.sv
// rtl/dac_spi_rx_spi_in_sync.sv - synchronizer chain plus edge detect for one SPI input
//   clk, rst : system clock, asynchronous active-high reset
//   din      : asynchronous pin
//   level    : synchronized level
//   rise     : one-cycle pulse on synchronized 0->1
//   fall     : one-cycle pulse on synchronized 1->0
module spi_in_sync
    import dac_spi_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/dac_spi_rx.sv
// rtl/dac_spi_rx.sv - SPI DAC-style frame receiver with channel input/output registers
//   clk, rst          : system clock, asynchronous active-high reset
//   spi_sclk/data/sync: SPI pins (sync active low, data sampled on sclk fall)
//   rd_addr, rd_data  : registered read of a channel output register
//   frame_valid/err   : one-cycle pulses for good / wrong-length frames
//   frame_comm/addr/data : fields of the last good frame
//   frame_cnt         : good frame counter (wraps)
module dac_spi_rx
    import dac_spi_rx_pkg::*;
#(
    parameter int DWIDTH      = 24,
    parameter int NCH         = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_sclk,
    input  logic        spi_data,
    input  logic        spi_sync,
    input  logic [3:0]  rd_addr,
    output logic [15:0] rd_data,
    output logic        frame_valid,
    output logic [3:0]  frame_comm,
    output logic [3:0]  frame_addr,
    output logic [15:0] frame_data,
    output logic        frame_err,
    output logic [15:0] frame_cnt
);

    localparam int            CW       = $clog2(DWIDTH + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(DWIDTH);
    localparam logic [CW-1:0] CNT_SAT  = CW'(DWIDTH + 1);

    logic sclk_lvl_unused, sclk_rise_unused, sclk_fall;
    logic data_lvl, data_rise_unused, data_fall_unused;
    logic sync_lvl, sync_rise, sync_fall;

    state_t state, state_nxt;

    logic [CW-1:0]     bit_cnt;
    logic [DWIDTH-1:0] shreg;
    logic [15:0]       in_reg  [NCH];
    logic [15:0]       out_reg [NCH];
    logic [15:0]       good_cnt;
    logic [15:0]       rd_mux;

    logic [3:0]  sh_comm, sh_addr;
    logic [15:0] sh_data;

    logic clr_cnt, shift_en, good, bad;

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst(rst), .din(spi_sclk),
        .level(sclk_lvl_unused), .rise(sclk_rise_unused), .fall(sclk_fall)
    );

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
        .clk(clk), .rst(rst), .din(spi_data),
        .level(data_lvl), .rise(data_rise_unused), .fall(data_fall_unused)
    );

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sync (
        .clk(clk), .rst(rst), .din(spi_sync),
        .level(sync_lvl), .rise(sync_rise), .fall(sync_fall)
    );

    assign sh_comm   = shreg[DWIDTH-1 -: 4];
    assign sh_addr   = shreg[DWIDTH-5 -: 4];
    assign sh_data   = shreg[15:0];
    assign frame_cnt = good_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WAIT_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Data and sclk share the same synchronizer depth, so data_lvl is
    // aligned with the detected sclk falling edge.
    always_comb begin
        state_nxt = state;
        clr_cnt   = 1'b0;
        shift_en  = 1'b0;
        good      = 1'b0;
        bad       = 1'b0;
        case (state)
            WAIT_IDLE: begin
                if (sync_lvl) state_nxt = IDLE;
            end
            IDLE: begin
                if (sync_fall) begin
                    state_nxt = SHIFT;
                    clr_cnt   = 1'b1;
                end
            end
            SHIFT: begin
                if (sync_rise) begin
                    state_nxt = EVAL;
                end else if (sclk_fall) begin
                    shift_en = 1'b1;
                end
            end
            EVAL: begin
                state_nxt = IDLE;
                good      = (bit_cnt == CNT_FULL);
                bad       = (bit_cnt != '0) && (bit_cnt != CNT_FULL);
            end
            default: state_nxt = WAIT_IDLE;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            if (rd_addr == 4'(ch)) rd_mux = out_reg[ch];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt     <= '0;
            shreg       <= '0;
            good_cnt    <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            frame_comm  <= '0;
            frame_addr  <= '0;
            frame_data  <= '0;
            rd_data     <= '0;
            for (int ch = 0; ch < NCH; ch++) begin
                in_reg[ch]  <= '0;
                out_reg[ch] <= '0;
            end
        end else begin
            frame_valid <= good;
            frame_err   <= bad;
            rd_data     <= rd_mux;

            if (clr_cnt) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                shreg <= {shreg[DWIDTH-2:0], data_lvl};
                // Saturating one past full marks an over-length frame.
                if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + CW'(1);
            end

            if (good) begin
                frame_comm <= sh_comm;
                frame_addr <= sh_addr;
                frame_data <= sh_data;
                good_cnt   <= good_cnt + 16'd1;
                for (int ch = 0; ch < NCH; ch++) begin
                    if (sh_comm == CMD_RST) begin
                        in_reg[ch]  <= '0;
                        out_reg[ch] <= '0;
                    end else if (sh_addr == ADDR_BCAST || sh_addr == 4'(ch)) begin
                        case (sh_comm)
                            CMD_WR_IN:  in_reg[ch] <= sh_data;
                            CMD_UPD:    out_reg[ch] <= in_reg[ch];
                            CMD_WR_UPD: begin
                                in_reg[ch]  <= sh_data;
                                out_reg[ch] <= sh_data;
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dac_spi_rx.sv
// tb/tb_dac_spi_rx.sv - directed self-checking bench for dac_spi_rx
module tb_dac_spi_rx;

    localparam int H = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_sclk, spi_data, spi_sync;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data;
    logic        frame_valid, frame_err;
    logic [3:0]  frame_comm, frame_addr;
    logic [15:0] frame_data, frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0;
    int valid_total = 0;
    int err_total = 0;
    int last_valid_cyc = 0;
    int sync_rise_cyc = 0;
    int v0, e0;

    dac_spi_rx dut (
        .clk(clk), .rst(rst),
        .spi_sclk(spi_sclk), .spi_data(spi_data), .spi_sync(spi_sync),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .frame_valid(frame_valid), .frame_comm(frame_comm),
        .frame_addr(frame_addr), .frame_data(frame_data),
        .frame_err(frame_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            valid_total++;
            last_valid_cyc = cyc;
        end
        if (frame_err === 1'b1) err_total++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic read_chk(input string tag, input logic [3:0] a, input logic [15:0] exp);
        rd_addr = a;
        @(negedge clk);
        check(tag, {16'h0, rd_data}, {16'h0, exp});
    endtask

    task automatic begin_frame();
        spi_sync = 1'b0;
        wait_clk(H);
    endtask

    task automatic send_bits(input int n, input logic [31:0] w);
        for (int i = n - 1; i >= 0; i--) begin
            spi_data = w[i];
            wait_clk(H);
            spi_sclk = 1'b0;
            wait_clk(H);
            spi_sclk = 1'b1;
        end
    endtask

    task automatic end_frame();
        wait_clk(H);
        spi_sync = 1'b1;
        sync_rise_cyc = cyc;
        wait_clk(12);
    endtask

    task automatic send_frame(input int n, input logic [31:0] w);
        v0 = valid_total;
        e0 = err_total;
        begin_frame();
        send_bits(n, w);
        end_frame();
    endtask

    initial begin
        rst      = 1'b1;
        spi_sclk = 1'b1;
        spi_data = 1'b0;
        spi_sync = 1'b1;
        rd_addr  = 4'h0;
        wait_clk(5);

        check("rst_frame_cnt",  {16'h0, frame_cnt},  32'h0);
        check("rst_rd_data",    {16'h0, rd_data},    32'h0);
        check("rst_valid",      {31'h0, frame_valid}, 32'h0);
        check("rst_err",        {31'h0, frame_err},  32'h0);
        check("rst_fields",     {8'h0, frame_comm, frame_addr, frame_data}, 32'h0);

        rst = 1'b0;
        wait_clk(10);

        // Write-and-update channel 2
        send_frame(24, 32'h0032ABCD);
        check("f1_valid_pulses", valid_total - v0, 1);
        check("f1_err_pulses",   err_total - e0,   0);
        check("f1_frame_cnt",    {16'h0, frame_cnt}, 32'd1);
        check("f1_fields",       {8'h0, frame_comm, frame_addr, frame_data}, 32'h0032ABCD);
        check("f1_latency",      last_valid_cyc - sync_rise_cyc, 4);
        read_chk("f1_rd_ch2", 4'h2, 16'hABCD);

        // Input write, then update
        send_frame(24, 32'h00051234);
        read_chk("wr_in_rd_ch5", 4'h5, 16'h0000);
        send_frame(24, 32'h00150000);
        read_chk("upd_rd_ch5", 4'h5, 16'h1234);
        check("upd_frame_cnt", {16'h0, frame_cnt}, 32'd3);

        // Broadcast write-and-update, then clear all
        send_frame(24, 32'h003F0FFF);
        for (int ch = 0; ch < 8; ch++) read_chk("bcast_rd", 4'(ch), 16'h0FFF);
        read_chk("bcast_rd_out_of_range", 4'h8, 16'h0000);
        send_frame(24, 32'h00700000);
        for (int ch = 0; ch < 8; ch++) read_chk("clear_rd", 4'(ch), 16'h0000);

        // Unknown command and out-of-range address change no channel
        send_frame(24, 32'h00345555);
        read_chk("ch4_set", 4'h4, 16'h5555);
        send_frame(24, 32'h0054AAAA);
        check("unk_cmd_valid", valid_total - v0, 1);
        read_chk("unk_cmd_ch4", 4'h4, 16'h5555);
        send_frame(24, 32'h0039BEEF);
        read_chk("addr9_ch4", 4'h4, 16'h5555);
        read_chk("addr9_rd9", 4'h9, 16'h0000);
        check("addr9_frame_cnt", {16'h0, frame_cnt}, 32'd8);
        check("addr9_fields", {8'h0, frame_comm, frame_addr, frame_data}, 32'h0039BEEF);

        // Short frame
        send_frame(23, 32'h001A0888);
        check("short_err",    err_total - e0,   1);
        check("short_valid",  valid_total - v0, 0);
        check("short_cnt",    {16'h0, frame_cnt}, 32'd8);
        check("short_fields", {8'h0, frame_comm, frame_addr, frame_data}, 32'h0039BEEF);
        read_chk("short_ch4", 4'h4, 16'h5555);

        // Long frame
        send_frame(25, 32'h01341111);
        check("long_err",    err_total - e0,   1);
        check("long_valid",  valid_total - v0, 0);
        check("long_cnt",    {16'h0, frame_cnt}, 32'd8);
        check("long_fields", {8'h0, frame_comm, frame_addr, frame_data}, 32'h0039BEEF);
        read_chk("long_ch4", 4'h4, 16'h5555);

        // Reset mid-frame with sync held low afterwards
        v0 = valid_total;
        e0 = err_total;
        begin_frame();
        send_bits(12, 32'h00000341);
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        send_bits(12, 32'h00000FFF);
        end_frame();
        check("midrst_valid", valid_total - v0, 0);
        check("midrst_err",   err_total - e0,   0);
        check("midrst_cnt",   {16'h0, frame_cnt}, 32'd0);
        read_chk("midrst_ch4", 4'h4, 16'h0000);
        send_frame(24, 32'h00341357);
        check("postrst_valid", valid_total - v0, 1);
        check("postrst_cnt",   {16'h0, frame_cnt}, 32'd1);
        read_chk("postrst_ch4", 4'h4, 16'h1357);

        // Counter wrap
        force dut.good_cnt = 16'hFFFF;
        wait_clk(1);
        release dut.good_cnt;
        wait_clk(1);
        check("wrap_preload", {16'h0, frame_cnt}, 32'h0000FFFF);
        send_frame(24, 32'h00010001);
        check("wrap_valid", valid_total - v0, 1);
        check("wrap_cnt",   {16'h0, frame_cnt}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
